mant_div_datapath: RTL and testbench

MANT_DIV_DATAPATH -- requirements
Module: mant_div_datapath

---
 rtl/mant_div_datapath.sv | 120 ++++++++++++
 tb/tb_mant_div_datapath.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mant_div_datapath.sv
// Restoring mantissa divider datapath: one quotient bit per step, 24 steps per divide.
// Produces a 24-bit quotient (1 integer + 23 fraction bits) plus a sticky bit for rounding.
module mant_div_datapath (
  input  logic        in_Clk,
  input  logic        in_Rst_N,
  input  logic        in_load,
  input  logic        in_shift_en,
  input  logic [23:0] in_mant_a,
  input  logic [23:0] in_mant_b,
  output logic [23:0] out_quotient,
  output logic        out_sticky,
  output logic        out_valid,
  output logic        out_done,
  output logic        out_busy,
  output logic        out_div_zero
);

  localparam int unsigned MANT_W = 24;
  localparam int unsigned REM_W  = 25;
  localparam int unsigned CNT_W  = 5;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MANT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [MANT_W-1:0]   quot_q, quot_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [REM_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic                dz_q, dz_d;
  logic                sticky_q, sticky_d;

  // Step operands: a load starts from the incoming operands instead of the registers.
  logic [REM_W-1:0]    rem_src;
  logic [REM_W-1:0]    div_src;
  logic [REM_W-1:0]    rem_sub;
  logic [REM_W-1:0]    rem_step;
  logic                q_bit;

  always_comb begin
    rem_src  = in_load ? {1'b0, in_mant_a} : rem_q;
    div_src  = in_load ? {1'b0, in_mant_b} : div_q;
    q_bit    = (rem_src >= div_src);
    rem_sub  = q_bit ? (rem_src - div_src) : rem_src;
    rem_step = REM_W'(rem_sub << 1);
  end

  // Next-state and register updates; every register holds unless a load or live shift fires.
  always_comb begin
    state_d = state_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    div_d   = div_q;
    count_d = count_q;
    dz_d    = dz_q;
    valid_d = 1'b0;

    if (in_load) begin
      state_d = S_RUN;
      rem_d   = rem_step;
      div_d   = div_src;
      quot_d  = {{(MANT_W-1){1'b0}}, q_bit};
      count_d = CNT_W'(1);
      dz_d    = (in_mant_b == '0);
    end else if (in_shift_en && (state_q == S_RUN)) begin
      rem_d   = rem_step;
      quot_d  = {quot_q[MANT_W-2:0], q_bit};
      count_d = CNT_W'(count_q + CNT_W'(1));
      if (count_q == LAST_CNT) begin
        state_d = S_DONE;
        valid_d = 1'b1;
      end
    end

    busy_d   = (state_d == S_RUN);
    done_d   = (state_d == S_DONE);
    sticky_d = (rem_d != '0) | dz_d;
  end

  always_ff @(posedge in_Clk) begin
    if (!in_Rst_N) begin
      state_q  <= S_IDLE;
      quot_q   <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      dz_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      dz_q     <= dz_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_quotient = quot_q;
  assign out_sticky   = sticky_q;
  assign out_valid    = valid_q;
  assign out_done     = done_q;
  assign out_busy     = busy_q;
  assign out_div_zero = dz_q;

endmodule

// File: tb/tb_mant_div_datapath.sv
// Scoreboard bench for mant_div_datapath: directed divides push expected results,
// a negedge monitor pops and checks them whenever out_valid is seen.
module tb_mant_div_datapath;

  logic        in_Clk = 1'b0;
  logic        in_Rst_N;
  logic        in_load;
  logic        in_shift_en;
  logic [23:0] in_mant_a;
  logic [23:0] in_mant_b;
  logic [23:0] out_quotient;
  logic        out_sticky;
  logic        out_valid;
  logic        out_done;
  logic        out_busy;
  logic        out_div_zero;

  mant_div_datapath dut (
    .in_Clk       (in_Clk),
    .in_Rst_N     (in_Rst_N),
    .in_load      (in_load),
    .in_shift_en  (in_shift_en),
    .in_mant_a    (in_mant_a),
    .in_mant_b    (in_mant_b),
    .out_quotient (out_quotient),
    .out_sticky   (out_sticky),
    .out_valid    (out_valid),
    .out_done     (out_done),
    .out_busy     (out_busy),
    .out_div_zero (out_div_zero)
  );

  always #5 in_Clk = ~in_Clk;

  typedef struct {
    logic [23:0] quot;
    logic        sticky;
    int unsigned edge_no;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  logic        mon_en = 1'b0;

  always @(posedge in_Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge in_Clk) begin
    if (mon_en && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 32'(out_quotient), 32'(e.quot));
        chk("sticky", 32'(out_sticky), 32'(e.sticky));
        chk("valid_edge", cyc, e.edge_no);
        chk("done_at_valid", 32'(out_done), 32'd1);
        chk("busy_at_valid", 32'(out_busy), 32'd0);
      end
    end
  end

  // Load edge followed by n_shift shift edges, with no expectation queued.
  task automatic load_only(input logic [23:0] a, input logic [23:0] b, input int n_shift);
    in_load = 1'b1; in_shift_en = 1'b1; in_mant_a = a; in_mant_b = b;
    @(negedge in_Clk);
    in_load = 1'b0;
    for (int i = 0; i < n_shift; i++) @(negedge in_Clk);
  endtask

  // Full divide with optional stall window; result checked by the monitor.
  task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic [23:0] eq,
                        input logic es, input int stall_at, input int stall_len);
    exp_t e;
    e.quot = eq; e.sticky = es; e.edge_no = cyc + 1 + 23 + stall_len;
    sb.push_back(e);
    in_load = 1'b1; in_shift_en = 1'b1; in_mant_a = a; in_mant_b = b;
    @(negedge in_Clk);
    in_load = 1'b0;
    chk("busy_after_load", 32'(out_busy), 32'd1);
    chk("div_zero_after_load", 32'(out_div_zero), 32'(b == 24'd0));
    chk("valid_after_load", 32'(out_valid), 32'd0);
    for (int i = 0; i < 23 + stall_len; i++) begin
      in_shift_en = !(i >= stall_at && i < stall_at + stall_len);
      @(negedge in_Clk);
    end
    // Shift stays high after completion: result must hold and valid must drop.
    in_shift_en = 1'b1;
    @(negedge in_Clk);
    chk("valid_drops", 32'(out_valid), 32'd0);
    chk("done_held", 32'(out_done), 32'd1);
    chk("quot_held", 32'(out_quotient), 32'(eq));
    chk("sticky_held", 32'(out_sticky), 32'(es));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    in_Rst_N = 1'b0; in_load = 1'b1; in_shift_en = 1'b1;
    in_mant_a = 24'h800000; in_mant_b = 24'h000000;
    repeat (2) @(negedge in_Clk);
    chk("rst_quot", 32'(out_quotient), 32'd0);
    chk("rst_busy", 32'(out_busy), 32'd0);
    chk("rst_done", 32'(out_done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_dz", 32'(out_div_zero), 32'd0);
    chk("rst_sticky", 32'(out_sticky), 32'd0);
    in_Rst_N = 1'b1; in_load = 1'b0;
    mon_en = 1'b1;
    @(negedge in_Clk);
    chk("idle_shift_busy", 32'(out_busy), 32'd0);

    run_op(24'h800000, 24'h800000, 24'h800000, 1'b0, 0, 0);
    run_op(24'hC00000, 24'h800000, 24'hC00000, 1'b0, 0, 0);
    run_op(24'h800000, 24'hC00000, 24'h555555, 1'b1, 0, 0);
    run_op(24'hFFFFFF, 24'h800000, 24'hFFFFFF, 1'b0, 0, 0);
    run_op(24'h000000, 24'h800000, 24'h000000, 1'b0, 0, 0);
    run_op(24'hC00000, 24'h800000, 24'hC00000, 1'b0, 8, 5);
    run_op(24'h123456, 24'h000000, 24'hFFFFFF, 1'b1, 0, 0);

    // Reload at count 10 aborts the first divide silently.
    load_only(24'hC00000, 24'hC00000, 9);
    run_op(24'h800000, 24'h800000, 24'h800000, 1'b0, 0, 0);

    // Reset for one edge at count 12.
    load_only(24'h800000, 24'hC00000, 11);
    in_Rst_N = 1'b0;
    @(negedge in_Clk);
    in_Rst_N = 1'b1;
    chk("midrst_quot", 32'(out_quotient), 32'd0);
    chk("midrst_busy", 32'(out_busy), 32'd0);
    chk("midrst_done", 32'(out_done), 32'd0);
    chk("midrst_sticky", 32'(out_sticky), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    repeat (30) @(negedge in_Clk);
    chk("midrst_idle_busy", 32'(out_busy), 32'd0);
    run_op(24'hC00000, 24'h800000, 24'hC00000, 1'b0, 0, 0);

    repeat (3) @(negedge in_Clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
